dat_tf_ctrl: RTL and testbench

- Transfer sequencer for the DAT physical layer.
- Accepts a transfer request from the register side (direction, block size, block count, single/multiple).
- Holds the transfer parameters stable and gates write_flag/read_flag with Tx-FIFO-empty / Rx-FIFO-full status.
- Supervises progress with a programmable timeout, resets the DAT datapath on abort or timeout, and reports completion and error status.

---
 rtl/dat_tf_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_dat_tf_ctrl.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dat_tf_ctrl.sv
// dat_tf_ctrl: transfer sequencer for the DAT physical layer.
// Latches a transfer request, holds the datapath parameters stable, and gates
// write_flag/read_flag with FIFO status. Supervises progress with an idle-cycle
// timeout, resets the datapath on abort or timeout, and reports the outcome.
// Optional build macro: DAT_AUTO_STOP_EN. When it is defined, multiple-block
// transfers wait in STOP_WAIT for the CMD side to issue the stop command.
// dbg_state exposes the FSM state for checkers.
module dat_tf_ctrl #(
  parameter int BLK_SZ_W  = 12,
  parameter int BLK_CNT_W = 16,
  parameter int TMO_W     = 16
) (
  input  logic                 sd_clk,
  input  logic                 rst_L,
  input  logic                 start,
  input  logic                 dir_read,
  input  logic                 multi_blk,
  input  logic [BLK_SZ_W-1:0]  block_sz_in,
  input  logic [BLK_CNT_W-1:0] block_cnt_in,
  input  logic                 abort,
  input  logic [TMO_W-1:0]     timeout_val,
  input  logic                 tx_fifo_empty,
  input  logic                 rx_fifo_full,
  input  logic                 phys_progress,
  input  logic                 phys_tf_finished,
  input  logic                 auto_stop_ack,
  output logic                 write_flag,
  output logic                 read_flag,
  output logic                 multiple,
  output logic [BLK_SZ_W-1:0]  block_sz,
  output logic [BLK_CNT_W-1:0] block_cnt,
  output logic                 phys_rst_L,
  output logic                 busy,
  output logic                 tf_complete,
  output logic                 err_cfg,
  output logic                 err_tmo,
  output logic                 err_abort,
  output logic                 auto_stop_req,
  output logic [2:0]           dbg_state
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ARM       = 3'd1;
  localparam logic [2:0] S_ACTIVE    = 3'd2;
  localparam logic [2:0] S_STOP_WAIT = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;
  localparam logic [2:0] S_ABORT     = 3'd5;

  localparam logic [BLK_CNT_W-1:0] ONE_BLK = {{(BLK_CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]           state_q, state_d;
  logic                 ph_q, ph_d;          // second cycle of ARM / ABORT
  logic [TMO_W-1:0]     cnt_q, cnt_d;        // idle cycles since last progress
  logic                 dir_q, dir_d;
  logic                 multiple_q, multiple_d;
  logic [BLK_SZ_W-1:0]  block_sz_q, block_sz_d;
  logic [BLK_CNT_W-1:0] block_cnt_q, block_cnt_d;
  logic                 err_cfg_q, err_cfg_d;
  logic                 err_tmo_q, err_tmo_d;
  logic                 err_abort_q, err_abort_d;
  logic                 wr_flag_q, wr_flag_d;
  logic                 rd_flag_q, rd_flag_d;
  logic                 cfg_ok;
  logic                 tmo_hit;
  logic [TMO_W-1:0]     cnt_inc;

  assign cfg_ok  = (block_sz_in != '0) && (block_sz_in[1:0] == 2'b00) &&
                   (!multi_blk || (block_cnt_in != '0));
  assign tmo_hit = (timeout_val != '0) && (cnt_q == timeout_val);
  // Progress clears the count; otherwise count up and stick at all-ones.
  assign cnt_inc = phys_progress ? '0 : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);

  // Next-state, parameter latching, sticky errors and flag gating.
  always_comb begin
    state_d     = state_q;
    ph_d        = 1'b0;
    cnt_d       = '0;
    dir_d       = dir_q;
    multiple_d  = multiple_q;
    block_sz_d  = block_sz_q;
    block_cnt_d = block_cnt_q;
    err_cfg_d   = err_cfg_q;
    err_tmo_d   = err_tmo_q;
    err_abort_d = err_abort_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_cfg_d   = 1'b0;
          err_tmo_d   = 1'b0;
          err_abort_d = 1'b0;
          if (cfg_ok) begin
            dir_d       = dir_read;
            multiple_d  = multi_blk;
            block_sz_d  = block_sz_in;
            block_cnt_d = multi_blk ? block_cnt_in : ONE_BLK;
            state_d     = S_ARM;
          end else begin
            err_cfg_d = 1'b1;
          end
        end
      end
      S_ARM: begin
        if (abort) begin
          state_d     = S_ABORT;
          err_abort_d = 1'b1;
        end else if (ph_q) begin
          state_d = S_ACTIVE;
        end else begin
          ph_d = 1'b1;
        end
      end
      S_ACTIVE: begin
        cnt_d = cnt_inc;
        if (phys_tf_finished) begin
`ifdef DAT_AUTO_STOP_EN
          state_d = multiple_q ? S_STOP_WAIT : S_DONE;
`else
          state_d = S_DONE;
`endif
        end else if (abort) begin
          state_d     = S_ABORT;
          err_abort_d = 1'b1;
        end else if (tmo_hit) begin
          state_d   = S_ABORT;
          err_tmo_d = 1'b1;
        end
      end
`ifdef DAT_AUTO_STOP_EN
      S_STOP_WAIT: begin
        cnt_d = cnt_inc;
        if (auto_stop_ack) begin
          state_d = S_DONE;
        end else if (abort) begin
          state_d     = S_ABORT;
          err_abort_d = 1'b1;
        end else if (tmo_hit) begin
          state_d   = S_ABORT;
          err_tmo_d = 1'b1;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      S_ABORT: begin
        if (ph_q) state_d = S_IDLE;
        else      ph_d    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Every state change starts the timeout window afresh.
    if (state_d != state_q) cnt_d = '0;
    // Flags are registered from the next state so they rise with ACTIVE.
    wr_flag_d = (state_d == S_ACTIVE) && !dir_q && !tx_fifo_empty;
    rd_flag_d = (state_d == S_ACTIVE) &&  dir_q && !rx_fifo_full;
  end

  // State and datapath-facing registers.
  always_ff @(posedge sd_clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q     <= S_IDLE;
      ph_q        <= 1'b0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      multiple_q  <= 1'b0;
      block_sz_q  <= '0;
      block_cnt_q <= '0;
      err_cfg_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      err_abort_q <= 1'b0;
      wr_flag_q   <= 1'b0;
      rd_flag_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      multiple_q  <= multiple_d;
      block_sz_q  <= block_sz_d;
      block_cnt_q <= block_cnt_d;
      err_cfg_q   <= err_cfg_d;
      err_tmo_q   <= err_tmo_d;
      err_abort_q <= err_abort_d;
      wr_flag_q   <= wr_flag_d;
      rd_flag_q   <= rd_flag_d;
    end
  end

  assign write_flag  = wr_flag_q;
  assign read_flag   = rd_flag_q;
  assign multiple    = multiple_q;
  assign block_sz    = block_sz_q;
  assign block_cnt   = block_cnt_q;
  assign phys_rst_L  = (state_q != S_ABORT);
  assign busy        = (state_q != S_IDLE);
  assign tf_complete = (state_q == S_DONE);
  assign err_cfg     = err_cfg_q;
  assign err_tmo     = err_tmo_q;
  assign err_abort   = err_abort_q;
  assign dbg_state   = state_q;

`ifdef DAT_AUTO_STOP_EN
  assign auto_stop_req = (state_q == S_STOP_WAIT);
`else
  // Without auto-stop the acknowledge has no meaning.
  logic unused_auto_stop_ack;
  assign unused_auto_stop_ack = auto_stop_ack;
  assign auto_stop_req        = 1'b0;
`endif

endmodule

// File: tb/tb_dat_tf_ctrl.sv
// Bench for dat_tf_ctrl: directed scenarios with a transfer-outcome scoreboard
// and a per-cycle read_flag expectation queue. Inputs change 1 time unit after
// the rising edge; outputs are sampled at the same point.
module tb_dat_tf_ctrl;
  localparam int BSW = 12;
  localparam int BCW = 16;
  localparam int TW  = 16;

  logic           sd_clk = 1'b0;
  logic           rst_L = 1'b1;
  logic           start = 1'b0;
  logic           dir_read = 1'b0;
  logic           multi_blk = 1'b0;
  logic [BSW-1:0] block_sz_in = '0;
  logic [BCW-1:0] block_cnt_in = '0;
  logic           abort = 1'b0;
  logic [TW-1:0]  timeout_val = '0;
  logic           tx_fifo_empty = 1'b1;
  logic           rx_fifo_full = 1'b0;
  logic           phys_progress = 1'b0;
  logic           phys_tf_finished = 1'b0;
  logic           auto_stop_ack = 1'b0;
  logic           write_flag, read_flag, multiple, phys_rst_L, busy, tf_complete;
  logic           err_cfg, err_tmo, err_abort, auto_stop_req;
  logic [BSW-1:0] block_sz;
  logic [BCW-1:0] block_cnt;
  logic [2:0]     dbg_state;

  int total = 0;
  int bad = 0;
  int cmpl_cnt = 0;
  int base = 0;
  // {completion pulses (clipped to 3), err_cfg, err_tmo, err_abort} per transfer
  logic [4:0] exp_q[$];
  logic [0:0] exp_flag_q[$];

  localparam logic [9:0] RST_VEC = 10'b0001000000;

  dat_tf_ctrl #(.BLK_SZ_W(BSW), .BLK_CNT_W(BCW), .TMO_W(TW)) dut (
    .sd_clk(sd_clk), .rst_L(rst_L), .start(start), .dir_read(dir_read),
    .multi_blk(multi_blk), .block_sz_in(block_sz_in), .block_cnt_in(block_cnt_in),
    .abort(abort), .timeout_val(timeout_val), .tx_fifo_empty(tx_fifo_empty),
    .rx_fifo_full(rx_fifo_full), .phys_progress(phys_progress),
    .phys_tf_finished(phys_tf_finished), .auto_stop_ack(auto_stop_ack),
    .write_flag(write_flag), .read_flag(read_flag), .multiple(multiple),
    .block_sz(block_sz), .block_cnt(block_cnt), .phys_rst_L(phys_rst_L),
    .busy(busy), .tf_complete(tf_complete), .err_cfg(err_cfg), .err_tmo(err_tmo),
    .err_abort(err_abort), .auto_stop_req(auto_stop_req), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 sd_clk = ~sd_clk;

  // completion monitor
  always @(negedge sd_clk) if (tf_complete === 1'b1) cmpl_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [9:0] out_vec();
    return {write_flag, read_flag, multiple, phys_rst_L, busy, tf_complete,
            err_cfg, err_tmo, err_abort, auto_stop_req};
  endfunction

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge sd_clk);
      #1;
    end
  endtask

  task automatic start_txn(input logic rd, input logic mul, input logic [BSW-1:0] bsz,
                           input logic [BCW-1:0] bcnt, input logic [4:0] expv);
    dir_read     = rd;
    multi_blk    = mul;
    block_sz_in  = bsz;
    block_cnt_in = bcnt;
    base         = cmpl_cnt;
    exp_q.push_back(expv);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  // scoreboard drain: wait for idle, then compare the transfer outcome
  task automatic end_txn(input string nm);
    int n;
    int d;
    logic [1:0] c;
    logic [4:0] got, e;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      cyc(1);
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: busy=%b required 0 within 200 cycles", nm, busy);
    end
    d = cmpl_cnt - base;
    c = (d > 3) ? 2'd3 : 2'(d);
    got = {c, err_cfg, err_tmo, err_abort};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s_sb: outcome %b with empty expected queue", nm, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        bad++;
        $display("FAIL %s_sb: outcome {cmpl,cfg,tmo,abort}=%b required %b", nm, got, e);
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_L = 1'b0;
    #2;
    total++;
    if (out_vec() !== RST_VEC) begin
      bad++; $display("FAIL reset_outs: got %b required %b", out_vec(), RST_VEC);
    end
    total++;
    if (block_sz !== '0 || block_cnt !== '0) begin
      bad++; $display("FAIL reset_params: block_sz=%0d block_cnt=%0d required 0 0", block_sz, block_cnt);
    end
    total++;
    if (dbg_state !== 3'd0) begin
      bad++; $display("FAIL reset_state: got %0d required 0", dbg_state);
    end
    cyc(2);
    rst_L = 1'b1;
    cyc(1);
  endtask

  task automatic test_single_write();
    tx_fifo_empty = 1'b0;
    start_txn(1'b0, 1'b0, 12'd512, 16'd7, {2'd1, 3'b000});
    total++;
    if ({busy, write_flag, multiple} !== 3'b100) begin
      bad++; $display("FAIL sw_arm1: busy,wflag,multiple=%b required 100", {busy, write_flag, multiple});
    end
    total++;
    if (block_sz !== 12'd512 || block_cnt !== 16'd1) begin
      bad++; $display("FAIL sw_latch: block_sz=%0d block_cnt=%0d required 512 1", block_sz, block_cnt);
    end
    cyc(1);
    total++;
    if (write_flag !== 1'b0) begin
      bad++; $display("FAIL sw_arm2: write_flag=%b required 0", write_flag);
    end
    cyc(1);
    total++;
    if (write_flag !== 1'b1 || read_flag !== 1'b0) begin
      bad++; $display("FAIL sw_wflag: write_flag=%b read_flag=%b required 1 0", write_flag, read_flag);
    end
    tx_fifo_empty = 1'b1;
    cyc(1);
    total++;
    if (write_flag !== 1'b0) begin
      bad++; $display("FAIL sw_empty: write_flag=%b required 0", write_flag);
    end
    tx_fifo_empty = 1'b0;
    phys_progress = 1'b1;
    cyc(3);
    phys_progress = 1'b0;
    phys_tf_finished = 1'b1;
    cyc(1);
    phys_tf_finished = 1'b0;
    total++;
    if ({tf_complete, write_flag, busy} !== 3'b101) begin
      bad++; $display("FAIL sw_done: tf_complete,wflag,busy=%b required 101", {tf_complete, write_flag, busy});
    end
    cyc(1);
    total++;
    if ({tf_complete, busy} !== 2'b00) begin
      bad++; $display("FAIL sw_idle: tf_complete,busy=%b required 00", {tf_complete, busy});
    end
    end_txn("single_write");
  endtask

  task automatic test_read_backpressure();
    int low;
    logic [0:0] e;
    rx_fifo_full = 1'b0;
    start_txn(1'b1, 1'b0, 12'd64, 16'd1, {2'd1, 3'b000});
    cyc(2);
    total++;
    if (read_flag !== 1'b1 || write_flag !== 1'b0) begin
      bad++; $display("FAIL rd_flag: read_flag=%b write_flag=%b required 1 0", read_flag, write_flag);
    end
    low = 0;
    for (int i = 0; i < 12; i++) begin
      rx_fifo_full = (i >= 2 && i < 7);
      exp_flag_q.push_back(!rx_fifo_full);
      cyc(1);
      e = exp_flag_q.pop_front();
      total++;
      if (read_flag !== e[0]) begin
        bad++; $display("FAIL rd_bp_%0d: read_flag=%b required %b", i, read_flag, e[0]);
      end
      if (read_flag === 1'b0) low++;
    end
    rx_fifo_full = 1'b0;
    total++;
    if (low != 5) begin
      bad++; $display("FAIL rd_low_cycles: got %0d required 5", low);
    end
    phys_tf_finished = 1'b1;
    cyc(1);
    phys_tf_finished = 1'b0;
    end_txn("read_bp");
  endtask

  task automatic test_illegal_cfg();
    logic [BSW-1:0] bsz_t[3] = '{12'd6, 12'd0, 12'd64};
    logic           mul_t[3] = '{1'b0, 1'b0, 1'b1};
    logic [BCW-1:0] cnt_t[3] = '{16'd1, 16'd1, 16'd0};
    for (int i = 0; i < 3; i++) begin
      start_txn(1'b0, mul_t[i], bsz_t[i], cnt_t[i], {2'd0, 3'b100});
      total++;
      if ({err_cfg, busy} !== 2'b10) begin
        bad++; $display("FAIL cfg_%0d: err_cfg,busy=%b required 10", i, {err_cfg, busy});
      end
      cyc(1);
      total++;
      if (busy !== 1'b0) begin
        bad++; $display("FAIL cfg_stay_%0d: busy=%b required 0", i, busy);
      end
      end_txn("illegal_cfg");
    end
    // legal start clears err_cfg, then abort while still in ARM
    start_txn(1'b0, 1'b1, 12'd128, 16'd2, {2'd0, 3'b001});
    total++;
    if ({err_cfg, busy, multiple} !== 3'b011 || block_cnt !== 16'd2) begin
      bad++; $display("FAIL cfg_clear: err_cfg,busy,multiple=%b block_cnt=%0d required 011 2",
                      {err_cfg, busy, multiple}, block_cnt);
    end
    abort = 1'b1;
    cyc(1);
    total++;
    if ({phys_rst_L, err_abort, write_flag} !== 3'b010) begin
      bad++; $display("FAIL arm_abort: rst_L,err_abort,wflag=%b required 010", {phys_rst_L, err_abort, write_flag});
    end
    cyc(1);
    total++;
    if (phys_rst_L !== 1'b0) begin
      bad++; $display("FAIL arm_abort2: phys_rst_L=%b required 0", phys_rst_L);
    end
    cyc(1);
    total++;
    if ({phys_rst_L, busy} !== 2'b10) begin
      bad++; $display("FAIL arm_abort_end: rst_L,busy=%b required 10", {phys_rst_L, busy});
    end
    cyc(1);
    total++;
    if ({phys_rst_L, busy} !== 2'b10) begin
      bad++; $display("FAIL idle_abort: rst_L,busy=%b required 10", {phys_rst_L, busy});
    end
    abort = 1'b0;
    end_txn("arm_abort");
  endtask

  task automatic test_timeout(input int prog_at, input int exp_n);
    int n;
    timeout_val   = 16'd10;
    tx_fifo_empty = 1'b0;
    start_txn(1'b0, 1'b1, 12'd16, 16'd4, {2'd0, 3'b010});
    cyc(2);
    total++;
    if (dbg_state !== 3'd2 || write_flag !== 1'b1 || multiple !== 1'b1 || block_cnt !== 16'd4) begin
      bad++; $display("FAIL tmo_active: state=%0d wflag=%b multiple=%b block_cnt=%0d required 2 1 1 4",
                      dbg_state, write_flag, multiple, block_cnt);
    end
    n = 0;
    while (phys_rst_L === 1'b1 && n < 100) begin
      phys_progress = (n == prog_at);
      cyc(1);
      n++;
    end
    phys_progress = 1'b0;
    total++;
    if (n != exp_n) begin
      bad++; $display("FAIL tmo_cycles_p%0d: abort after %0d cycles required %0d", prog_at, n, exp_n);
    end
    total++;
    if ({err_tmo, err_abort, write_flag, tf_complete} !== 4'b1000) begin
      bad++; $display("FAIL tmo_flags: tmo,abort,wflag,tf=%b required 1000",
                      {err_tmo, err_abort, write_flag, tf_complete});
    end
    cyc(1);
    total++;
    if (phys_rst_L !== 1'b0) begin
      bad++; $display("FAIL tmo_rst2: phys_rst_L=%b required 0", phys_rst_L);
    end
    cyc(1);
    total++;
    if ({phys_rst_L, busy} !== 2'b10) begin
      bad++; $display("FAIL tmo_end: rst_L,busy=%b required 10", {phys_rst_L, busy});
    end
    timeout_val = '0;
    end_txn("timeout");
  endtask

  task automatic test_abort_vs_finish();
    tx_fifo_empty = 1'b0;
    start_txn(1'b0, 1'b0, 12'd32, 16'd1, {2'd1, 3'b000});
    cyc(2);
    abort = 1'b1;
    phys_tf_finished = 1'b1;
    cyc(1);
    abort = 1'b0;
    phys_tf_finished = 1'b0;
    total++;
    if ({tf_complete, err_abort, phys_rst_L} !== 3'b101) begin
      bad++; $display("FAIL abort_vs_fin: tf,err_abort,rst_L=%b required 101", {tf_complete, err_abort, phys_rst_L});
    end
    end_txn("abort_vs_finish");
    rx_fifo_full = 1'b0;
    start_txn(1'b1, 1'b0, 12'd32, 16'd1, {2'd0, 3'b001});
    cyc(2);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    total++;
    if ({phys_rst_L, err_abort, read_flag, tf_complete} !== 4'b0100) begin
      bad++; $display("FAIL active_abort: rst_L,err_abort,rflag,tf=%b required 0100",
                      {phys_rst_L, err_abort, read_flag, tf_complete});
    end
    end_txn("active_abort");
  endtask

  task automatic test_reset_mid();
    tx_fifo_empty = 1'b0;
    start_txn(1'b0, 1'b1, 12'd512, 16'd3, {2'd0, 3'b000});
    cyc(2);
    total++;
    if (write_flag !== 1'b1) begin
      bad++; $display("FAIL mid_pre: write_flag=%b required 1", write_flag);
    end
    #3 rst_L = 1'b0;
    #1;
    total++;
    if (out_vec() !== RST_VEC || block_sz !== '0 || block_cnt !== '0) begin
      bad++; $display("FAIL mid_reset: outs=%b block_sz=%0d block_cnt=%0d required %b 0 0",
                      out_vec(), block_sz, block_cnt, RST_VEC);
    end
    cyc(2);
    rst_L = 1'b1;
    cyc(1);
    end_txn("reset_mid");
  endtask

  task automatic test_auto_stop();
    tx_fifo_empty = 1'b0;
    start_txn(1'b0, 1'b1, 12'd512, 16'd4, {2'd1, 3'b000});
    cyc(2);
`ifdef DAT_AUTO_STOP_EN
    phys_tf_finished = 1'b1;
    cyc(1);
    phys_tf_finished = 1'b0;
    total++;
    if ({auto_stop_req, tf_complete, busy} !== 3'b101) begin
      bad++; $display("FAIL as_req: req,tf,busy=%b required 101", {auto_stop_req, tf_complete, busy});
    end
    cyc(3);
    total++;
    if ({auto_stop_req, tf_complete} !== 2'b10) begin
      bad++; $display("FAIL as_hold: req,tf=%b required 10", {auto_stop_req, tf_complete});
    end
    auto_stop_ack = 1'b1;
    cyc(1);
    auto_stop_ack = 1'b0;
    total++;
    if ({auto_stop_req, tf_complete} !== 2'b01) begin
      bad++; $display("FAIL as_ack: req,tf=%b required 01", {auto_stop_req, tf_complete});
    end
`else
    auto_stop_ack = 1'b1;
    phys_tf_finished = 1'b1;
    cyc(1);
    phys_tf_finished = 1'b0;
    auto_stop_ack = 1'b0;
    total++;
    if ({auto_stop_req, tf_complete} !== 2'b01) begin
      bad++; $display("FAIL no_as: req,tf=%b required 01", {auto_stop_req, tf_complete});
    end
`endif
    end_txn("auto_stop");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_backpressure();
    test_illegal_cfg();
    test_timeout(-1, 11);
    test_timeout(4, 16);
    test_abort_vs_finish();
    test_reset_mid();
    test_auto_stop();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL sb_leftover: %0d entries required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
